// File: rtl/led_mon_pkg.sv
// Shared types and default constants for the blink-line monitor.
package led_mon_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_TRACK  = 3'd2,
        S_LOCKED = 3'd3,
        S_STUCK  = 3'd4
    } state_e;

    localparam int unsigned DEF_CNT_W      = 32;
    localparam int unsigned DEF_TIMEOUT    = 1000;
    localparam int unsigned DEF_LOCK_COUNT = 4;
    localparam int unsigned EDGE_CNT_W     = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level plus a toggle detector
// on the synchronized value.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_c   = sync_out ^ prev_q;

endmodule

// File: rtl/led_blink_monitor.sv
// Measures the toggle interval of an asynchronous blink line, declares lock
// on a stable rate and flags a line that stops toggling.
module led_blink_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TOLERANCE   = 0,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  led_in,
    output logic [CNT_W-1:0]      half_period,
    output logic                  period_valid,
    output logic                  locked,
    output logic                  stuck,
    output logic [EDGE_CNT_W-1:0] edge_count
);

    localparam int unsigned IW = CNT_W + 1;
    localparam int unsigned MW = $clog2(LOCK_COUNT) + 1;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IW-1:0]    TOL_V     = IW'(TOLERANCE);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MW-1:0]           match_q, match_d;
    logic [IW-1:0]           prev_q, prev_d;
    logic [CNT_W-1:0]        hp_q, hp_d;
    logic                    pv_q, pv_d;
    logic                    locked_q, locked_d;
    logic                    stuck_q, stuck_d;
    logic [EDGE_CNT_W-1:0]   ec_q, ec_d;

    logic                    edge_c;
    logic                    sync_unused;
    logic [IW-1:0]           interval_c;
    logic [IW-1:0]           diff_c;
    logic                    is_match_c;
    logic                    timeout_c;
    logic                    measure_c;
    logic [MW-1:0]           match_inc_c;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (led_in),
        .sync_out (sync_unused),
        .edge_c   (edge_c)
    );

    // Interval and distance are one bit wider than the counter so cnt+1 and
    // the absolute difference never wrap.
    assign interval_c  = {1'b0, cnt_q} + IW'(1);
    assign diff_c      = (interval_c >= prev_q) ? (interval_c - prev_q) : (prev_q - interval_c);
    assign is_match_c  = (diff_c <= TOL_V);
    assign timeout_c   = (cnt_q == TIMEOUT_V) && !edge_c;
    assign match_inc_c = match_q + MW'(1);
    assign measure_c   = edge_c && ((state_q == S_FIRST) || (state_q == S_TRACK) ||
                                    (state_q == S_LOCKED));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            prev_q   <= '0;
            hp_q     <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            stuck_q  <= 1'b0;
            ec_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            prev_q   <= prev_d;
            hp_q     <= hp_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            stuck_q  <= stuck_d;
            ec_q     <= ec_d;
        end
    end

    // Next state: an edge always takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (edge_c)         state_d = S_FIRST;
                else if (timeout_c) state_d = S_STUCK;
            end
            S_FIRST: begin
                if (edge_c)         state_d = S_TRACK;
                else if (timeout_c) state_d = S_STUCK;
            end
            S_TRACK: begin
                if (edge_c) begin
                    if (is_match_c && (match_inc_c == LOCK_LAST)) state_d = S_LOCKED;
                end else if (timeout_c) begin
                    state_d = S_STUCK;
                end
            end
            S_LOCKED: begin
                if (edge_c) begin
                    if (!is_match_c) state_d = S_TRACK;
                end else if (timeout_c) begin
                    state_d = S_STUCK;
                end
            end
            S_STUCK: begin
                if (edge_c) state_d = S_FIRST;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered output values.
    always_comb begin
        cnt_d    = cnt_q;
        match_d  = match_q;
        prev_d   = prev_q;
        hp_d     = hp_q;
        pv_d     = 1'b0;
        ec_d     = ec_q;
        locked_d = (state_d == S_LOCKED);
        stuck_d  = (state_d == S_STUCK);

        if (edge_c) begin
            cnt_d = '0;
            ec_d  = ec_q + EDGE_CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (measure_c) begin
            pv_d   = 1'b1;
            hp_d   = CNT_W'(interval_c);
            prev_d = interval_c;
            case (state_q)
                S_FIRST:  match_d = '0;
                S_TRACK:  match_d = is_match_c ? match_inc_c : '0;
                S_LOCKED: match_d = is_match_c ? match_q : '0;
                default:  match_d = match_q;
            endcase
        end
    end

    assign half_period  = hp_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign stuck        = stuck_q;
    assign edge_count   = ec_q;

endmodule
